// File: rtl/lsu_bus_if.sv
// Load/store bus interface: runs one mem-stage access on a req/gnt/rvalid word bus, stalling meanwhile.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module lsu_bus_if #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wmem_en_i,
    input  logic                  rmem_en_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    input  logic [2:0]            funct3_i,
    output logic [31:0]           rdata_o,
    output logic                  stall_o,
    output logic                  err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [31:0]           bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [31:0]           bus_rdata_i
);
    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            off_q, off_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    logic        is_byte, is_half, misalign, expire;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic        unused_funct3;

    // Sign handling lives upstream, so the sign bit of funct3 is not needed here.
    assign unused_funct3 = funct3_i[2];

    always_comb begin
        is_byte = (funct3_i[1:0] == 2'b00);
        is_half = (funct3_i[1:0] == 2'b01);
        if (is_byte) begin
            off       = mem_addr_i[1:0];
            be        = 4'b0001 << off;
            wdata_rep = {4{mem_wdata_i[7:0]}};
        end else if (is_half) begin
            off       = {mem_addr_i[1], 1'b0};
            be        = 4'b0011 << off;
            wdata_rep = {2{mem_wdata_i[15:0]}};
        end else begin
            off       = 2'b00;
            be        = 4'b1111;
            wdata_rep = mem_wdata_i;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (is_half & mem_addr_i[0]) |
                      (!is_byte & !is_half & (mem_addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // An access completes only if its finishing handshake (gnt for a store, rvalid for a load)
    // lands within the first TIMEOUT_CYCLES waiting cycles; a load gnt on the last one is too late.
    assign expire = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (wmem_en_i | rmem_en_i) begin
                    we_d    = wmem_en_i;
                    addr_d  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    be_d    = be;
                    wdata_d = wdata_rep;
                    off_d   = off;
                    cnt_d   = 8'd0;
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        req_d   = 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (bus_gnt_i && (we_q || !expire)) begin
                    req_d   = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = we_q ? StDone : StResp;
                end else if (expire) begin
                    req_d   = 1'b0;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                if (bus_rvalid_i) begin
                    rdata_d = bus_rdata_i >> {off_q, 3'b000};
                    state_d = StDone;
                end else if (expire) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            off_q   <= 2'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_o     = (wmem_en_i | rmem_en_i) & (state_q != StDone);
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Bench for lsu_bus_if: directed and random accesses against a cycle-count/lane reference model.
module tb_lsu_bus_if;
    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wmem_en, rmem_en;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata_o;
    logic        stall_o, err_o, bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    lsu_bus_if #(
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wmem_en_i   (wmem_en),
        .rmem_en_i   (rmem_en),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .funct3_i    (funct3),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_gnt_i   (bus_gnt),
        .bus_rvalid_i(bus_rvalid),
        .bus_rdata_i (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One IDLE cycle with no request: everything quiet.
    task automatic idle_check(input string tag);
        #1;
        check32({tag, "_idle"}, {27'd0, stall_o, err_o, bus_req_o, 2'b00}, 32'd0);
        check32({tag, "_idle_rdata"}, rdata_o, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Runs one access starting in an IDLE cycle; g = REQ cycles before gnt, r = RESP cycles
    // before rvalid. Expected values come from the access size/offset and cycle budget.
    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] brd, input int g,
                          input int r, input string tag);
        int          nb, off, stalls, reqs, bad, rseen, exp_stalls, exp_reqs;
        bit          trap, ok, in_resp, done;
        logic [31:0] eff, exp_addr, exp_wd, exp_rd, wdz;
        logic [3:0]  exp_be;

        nb  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        wdz = (nb == 4) ? wd : (wd & ((32'd1 << (8 * nb)) - 32'd1));
        eff = addr - (addr % nb);
        off = int'(eff % 4);
        exp_addr = addr - (addr % 4);
        exp_be   = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdz[8*(i % nb) +: 8];
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (addr % nb) != 0;
`else
        trap = 1'b0;
`endif
        ok = st ? (g < T) : (g + r + 2 <= T);
        if (trap) begin
            exp_stalls = 1;
            exp_reqs   = 0;
            ok         = 1'b0;
        end else begin
            exp_stalls = ok ? (st ? g + 2 : g + r + 3) : T + 1;
            exp_reqs   = (g + 1 < T) ? g + 1 : T;
        end
        exp_rd = (ok && !st) ? (brd >> (8 * off)) : 32'd0;

        stalls = 0; reqs = 0; bad = 0; rseen = 0; in_resp = 0; done = 0;
        wmem_en = st; rmem_en = !st; mem_addr = addr; mem_wdata = wdz; funct3 = f3;
        bus_rdata = brd;
        for (int cyc = 0; cyc < 4 * T + 8 && !done; cyc++) begin
            bus_gnt    = bus_req_o && (reqs == g);
            bus_rvalid = in_resp && (rseen == r);
            #1;
            if (bus_req_o) begin
                reqs++;
                if (bus_addr_o !== exp_addr || bus_be_o !== exp_be || bus_we_o !== st ||
                    (st && bus_wdata_o !== exp_wd)) bad++;
                if (bus_gnt && !st) in_resp = 1;
            end else if (in_resp) begin
                rseen++;
            end
            if (stall_o) begin
                stalls++;
            end else begin
                done = 1;
                check32({tag, "_rdata"}, rdata_o, exp_rd);
                check32({tag, "_err"}, {31'd0, err_o}, {31'd0, !ok});
            end
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        check32({tag, "_done"}, {31'd0, done}, 32'd1);
        check32({tag, "_bus"}, bad, 32'd0);
        check32({tag, "_reqcycles"}, reqs, exp_reqs);
        check32({tag, "_stalls"}, stalls, exp_stalls);
        bus_gnt = 0; bus_rvalid = 0;
        @(posedge clk);
        #1;
        wmem_en = 0; rmem_en = 0;
    endtask

    initial begin
        int          g, r, sz;
        bit          st;
        logic [2:0]  f3;

        rst = 1; wmem_en = 0; rmem_en = 0; mem_addr = 0; mem_wdata = 0; funct3 = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_ctrl", {24'd0, bus_req_o, bus_we_o, err_o, stall_o, bus_be_o}, 32'd0);
        check32("reset_addr", bus_addr_o, 32'd0);
        check32("reset_wdata", bus_wdata_o, 32'd0);
        check32("reset_rdata", rdata_o, 32'd0);
        rst = 0;
        @(posedge clk);
        #1;

        access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, "st_byte");
        idle_check("st_byte");
        access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0, "ld_half");
        access(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 4, 2, "ld_word_slow");
        access(1'b0, 3'b010, 32'h0000_3100, 32'h0, 32'h1234_5678, T, 0, "timeout");
        idle_check("timeout");
        access(1'b1, 3'b001, 32'h0000_3202, 32'h0000_ABCD, 32'h0, 1, 0, "b2b_store");
        access(1'b0, 3'b100, 32'h0000_3201, 32'h0, 32'h8899_AABB, 0, 1, "b2b_load");
        access(1'b0, 3'b010, 32'h0000_4001, 32'h0, 32'h1122_3344, 0, 0, "misalign_word");
        idle_check("misalign_word");

        // Reset while waiting for rvalid; a late rvalid must not resurrect the access.
        rmem_en = 1; mem_addr = 32'h0000_5004; funct3 = 3'b010;
        @(posedge clk);
        #1;
        bus_gnt = 1;
        @(posedge clk);
        #1;
        bus_gnt = 0; rst = 1;
        @(posedge clk);
        #1;
        rst = 0; rmem_en = 0; bus_rvalid = 1; bus_rdata = 32'hCAFE_F00D;
        #1;
        check32("midrst_ctrl", {24'd0, bus_req_o, bus_we_o, err_o, stall_o, bus_be_o}, 32'd0);
        check32("midrst_addr", bus_addr_o, 32'd0);
        @(posedge clk);
        #1;
        bus_rvalid = 0;
        check32("midrst_rvalid_ignored", rdata_o, 32'd0);
        @(posedge clk);
        #1;
        access(1'b0, 3'b010, 32'h0000_5008, 32'h0, 32'h0BAD_F00D, 0, 0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            sz = int'($urandom_range(0, 2));
            f3 = {1'($urandom_range(0, 1)), 2'(sz)};
            g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T + 1))
                                             : int'($urandom_range(0, 2));
            r  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T))
                                             : int'($urandom_range(0, 2));
            access(st, f3, $urandom, $urandom, $urandom, g, r, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
